// File: rtl/lc_line_responder_pkg.sv
// Shared types and helpers for the line responder: request record,
// responder FSM states and line-address alignment.
package mem_line_pkg;

    localparam int LINE_B       = 64;
    localparam int PADDR_W      = 22;
    localparam int STORE_LINES  = 256;
    localparam int SVC_LATENCY  = 4;
    localparam int REQ_QDEPTH   = 4;
    localparam int LINE_OFF_W   = $clog2(LINE_B);

    typedef struct packed {
        logic [PADDR_W-1:0]  paddr;
        logic                we;
        logic [8*LINE_B-1:0] line;
    } line_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } resp_state_t;

    // Clear the byte-offset bits so the address names the start of its line.
    function automatic logic [PADDR_W-1:0] align_line(input logic [PADDR_W-1:0] addr);
        return {addr[PADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/lc_line_responder_fifo.sv
// In-order request queue. Occupancy is held in a register so that the
// upstream ready can be derived from state only.
module line_req_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk_in,
    input  logic                     rst_N_in,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    T               mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW:0]    count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign full      = (count_r == (PW+1)'(DEPTH));
    assign empty     = (count_r == {(PW+1){1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk_in) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lc_line_responder.sv
// Lower-level line responder: queues line reads and writebacks, services
// each after a fixed latency from an internal line store, and returns a
// full line for every read. Writebacks complete without a response.
module lc_line_responder
    import mem_line_pkg::*;
#(
    parameter int B          = LINE_B,
    parameter int PADDR_BITS = PADDR_W,
    parameter int LINES      = STORE_LINES,
    parameter int LATENCY    = SVC_LATENCY,
    parameter int QDEPTH     = REQ_QDEPTH
) (
    input  logic                   clk_in,
    input  logic                   rst_N_in,
    input  logic                   hc_valid_in,
    output logic                   hc_ready_out,
    input  logic [PADDR_BITS-1:0]  hc_addr_in,
    input  logic [8*B-1:0]         hc_value_in,
    input  logic                   hc_we_in,
    output logic                   hc_valid_out,
    input  logic                   hc_ready_in,
    output logic [PADDR_BITS-1:0]  hc_addr_out,
    output logic [8*B-1:0]         hc_value_out
);

    localparam int OFF = $clog2(B);
    localparam int IDX = $clog2(LINES);
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int QCW = $clog2(QDEPTH) + 1;

    line_req_t             fifo_din_s;
    line_req_t             fifo_dout_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [QCW-1:0]        fifo_count_s;

    resp_state_t           state_r, state_nxt_s;
    logic [CW-1:0]         cnt_r, cnt_nxt_s;
    line_req_t             work_r, work_nxt_s;
    logic                  valid_out_r, valid_out_nxt_s;
    logic [PADDR_BITS-1:0] addr_out_r, addr_out_nxt_s;
    logic [8*B-1:0]        value_out_r, value_out_nxt_s;
    logic                  store_we_s;
    logic [IDX-1:0]        work_idx_s;

    logic [8*B-1:0]        store_r [LINES];
    logic [LINES-1:0]      line_valid_r;

    assign hc_ready_out = (fifo_count_s < QCW'(QDEPTH));
    assign fifo_push_s  = hc_valid_in && hc_ready_out && !fifo_full_s;
    assign fifo_din_s   = '{paddr: hc_addr_in, we: hc_we_in, line: hc_value_in};
    assign work_idx_s   = work_r.paddr[OFF +: IDX];

    assign hc_valid_out = valid_out_r;
    assign hc_addr_out  = addr_out_r;
    assign hc_value_out = value_out_r;

    line_req_fifo #(
        .DEPTH (QDEPTH),
        .T     (line_req_t)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_N_in (rst_N_in),
        .push     (fifo_push_s),
        .pop      (fifo_pop_s),
        .din      (fifo_din_s),
        .dout     (fifo_dout_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    // Service sequencing: pop in IDLE, count down in BUSY, hold response in RESPOND.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        work_nxt_s      = work_r;
        valid_out_nxt_s = valid_out_r;
        addr_out_nxt_s  = addr_out_r;
        value_out_nxt_s = value_out_r;
        fifo_pop_s      = 1'b0;
        store_we_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    work_nxt_s  = fifo_dout_s;
                    cnt_nxt_s   = CW'(LATENCY - 1);
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end else if (work_r.we) begin
                    store_we_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    // A line never written since reset reads back as zeros.
                    value_out_nxt_s = line_valid_r[work_idx_s] ? store_r[work_idx_s]
                                                                : {(8*B){1'b0}};
                    addr_out_nxt_s  = align_line(work_r.paddr);
                    valid_out_nxt_s = 1'b1;
                    state_nxt_s     = RESPOND;
                end
            end
            RESPOND: begin
                if (hc_ready_in) begin
                    valid_out_nxt_s = 1'b0;
                    state_nxt_s     = IDLE;
                end else begin
                    state_nxt_s = RESPOND;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                valid_out_nxt_s = 1'b0;
            end
        endcase
    end

    // Control state and registered response outputs.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            work_r      <= '0;
            valid_out_r <= 1'b0;
            addr_out_r  <= {PADDR_BITS{1'b0}};
            value_out_r <= {(8*B){1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            work_r      <= work_nxt_s;
            valid_out_r <= valid_out_nxt_s;
            addr_out_r  <= addr_out_nxt_s;
            value_out_r <= value_out_nxt_s;
        end
    end

    // Per-line valid bits; reset forgets every stored line.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            line_valid_r <= {LINES{1'b0}};
        end else if (store_we_s) begin
            line_valid_r[work_idx_s] <= 1'b1;
        end
    end

    // Line data array, written when a writeback completes; not reset.
    always_ff @(posedge clk_in) begin
        if (store_we_s) begin
            store_r[work_idx_s] <= work_r.line;
        end
    end

endmodule

// File: tb/tb_lc_line_responder.sv
// Directed bench for lc_line_responder: a vector table of writeback/read
// transactions plus hand-written sequences for latency, back-pressure,
// back-to-back service and reset during service.
module tb_lc_line_responder;

    localparam int AW = 22;
    localparam int LW = 512;

    logic          clk_in = 1'b0;
    logic          rst_N_in;
    logic          hc_valid_in;
    logic          hc_ready_out;
    logic [AW-1:0] hc_addr_in;
    logic [LW-1:0] hc_value_in;
    logic          hc_we_in;
    logic          hc_valid_out;
    logic          hc_ready_in;
    logic [AW-1:0] hc_addr_out;
    logic [LW-1:0] hc_value_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] value;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_value;
    } vec_t;

    vec_t vecs [8];

    lc_line_responder dut (
        .clk_in       (clk_in),
        .rst_N_in     (rst_N_in),
        .hc_valid_in  (hc_valid_in),
        .hc_ready_out (hc_ready_out),
        .hc_addr_in   (hc_addr_in),
        .hc_value_in  (hc_value_in),
        .hc_we_in     (hc_we_in),
        .hc_valid_out (hc_valid_out),
        .hc_ready_in  (hc_ready_in),
        .hc_addr_out  (hc_addr_out),
        .hc_value_out (hc_value_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and return at the negedge after it is accepted.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] value);
        int n;
        hc_valid_in = 1'b1;
        hc_we_in    = we;
        hc_addr_in  = addr;
        hc_value_in = value;
        n = 0;
        while (!hc_ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!hc_ready_out) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=ready_low required=ready_high");
        end
        @(negedge clk_in);
        hc_valid_in = 1'b0;
    endtask

    // Wait (bounded) for a response, compare it, and complete the handshake.
    task automatic wait_resp(input string name, input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_value);
        int n;
        hc_ready_in = 1'b1;
        n = 0;
        while (!hc_valid_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check({name, "_valid"}, LW'(hc_valid_out), LW'(1'b1));
        check({name, "_addr"}, LW'(hc_addr_out), LW'(exp_addr));
        check({name, "_value"}, hc_value_out, exp_value);
        @(negedge clk_in);
    endtask

    // Count cycles with a response visible; none are expected.
    task automatic quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_in);
            if (hc_valid_out) seen++;
        end
        check(name, LW'(seen), LW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] pat_p;
        logic [LW-1:0] pat_a;
        logic [LW-1:0] pat_b;
        logic [LW-1:0] pat_c;
        logic [AW-1:0] q_addr [5];
        logic [LW-1:0] q_val  [5];
        int early;
        int bad;
        int n;

        pat_p = {8{64'hDEAD_BEEF_0000_0001}};
        pat_a = {8{64'h0123_4567_89AB_CDEF}};
        pat_b = {8{64'hA5A5_5A5A_F00D_CAFE}};
        pat_c = {8{64'h1C0C_1C0C_7777_0005}};

        vecs[0] = '{1'b1, 22'h000080, pat_p, 22'h0, '0};
        vecs[1] = '{1'b0, 22'h0000A8, '0, 22'h000080, pat_p};
        vecs[2] = '{1'b1, 22'h000000, pat_a, 22'h0, '0};
        vecs[3] = '{1'b0, 22'h004000, '0, 22'h004000, pat_a};
        vecs[4] = '{1'b0, 22'h001000, '0, 22'h001000, '0};
        vecs[5] = '{1'b1, 22'h003FC0, pat_b, 22'h0, '0};
        vecs[6] = '{1'b0, 22'h003FFF, '0, 22'h003FC0, pat_b};
        vecs[7] = '{1'b0, 22'h000000, '0, 22'h000000, pat_a};

        rst_N_in    = 1'b0;
        hc_valid_in = 1'b0;
        hc_addr_in  = '0;
        hc_value_in = '0;
        hc_we_in    = 1'b0;
        hc_ready_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_valid", LW'(hc_valid_out), LW'(1'b0));
        check("rst_addr", LW'(hc_addr_out), LW'(0));
        check("rst_value", hc_value_out, '0);
        rst_N_in = 1'b1;
        #1;
        check("rst_ready", LW'(hc_ready_out), LW'(1'b1));
        @(negedge clk_in);

        // Test 1: unwritten read, response visible exactly after E0+5
        send(1'b0, 22'h000040, '0);
        early = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_in);
            if (hc_valid_out) early++;
        end
        check("t1_early", LW'(early), LW'(0));
        @(negedge clk_in);
        check("t1_valid", LW'(hc_valid_out), LW'(1'b1));
        check("t1_addr", LW'(hc_addr_out), LW'(22'h000040));
        check("t1_value", hc_value_out, '0);
        hc_ready_in = 1'b1;
        @(negedge clk_in);
        check("t1_drop", LW'(hc_valid_out), LW'(1'b0));

        // Vector table: writes stay silent, reads return store contents
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].value);
            if (vecs[i].we) begin
                quiet($sformatf("vec%0d_noresp", i), 8);
            end else begin
                wait_resp($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_value);
            end
        end

        // Test 3: back-pressure with a held response and a full queue
        hc_ready_in = 1'b0;
        send(1'b0, 22'h000040, '0);
        n = 0;
        while (!hc_valid_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("t3_r0_valid", LW'(hc_valid_out), LW'(1'b1));
        q_addr[0] = 22'h000080; q_val[0] = pat_p;
        q_addr[1] = 22'h004000; q_val[1] = pat_a;
        q_addr[2] = 22'h003FC0; q_val[2] = pat_b;
        q_addr[3] = 22'h001000; q_val[3] = '0;
        q_addr[4] = 22'h004080; q_val[4] = pat_p;
        hc_we_in    = 1'b0;
        hc_value_in = '0;
        for (int i = 0; i < 4; i++) begin
            hc_valid_in = 1'b1;
            hc_addr_in  = q_addr[i];
            check($sformatf("t3_ready%0d", i), LW'(hc_ready_out), LW'(1'b1));
            @(negedge clk_in);
        end
        check("t3_full", LW'(hc_ready_out), LW'(1'b0));
        hc_addr_in = q_addr[4];
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (hc_ready_out || !hc_valid_out || hc_addr_out != 22'h000040 || hc_value_out != '0) bad++;
        end
        check("t3_hold", LW'(bad), LW'(0));
        hc_ready_in = 1'b1;
        @(negedge clk_in);
        check("t3_drop", LW'(hc_valid_out), LW'(1'b0));
        check("t3_still_full", LW'(hc_ready_out), LW'(1'b0));
        send(1'b0, q_addr[4], '0);
        for (int i = 0; i < 5; i++) begin
            wait_resp($sformatf("t3_q%0d", i), q_addr[i] & 22'h3FFFC0, q_val[i]);
        end

        // Test 5: write and read of the same line on consecutive cycles
        hc_valid_in = 1'b1;
        hc_we_in    = 1'b1;
        hc_addr_in  = 22'h0001C0;
        hc_value_in = pat_c;
        @(negedge clk_in);
        check("t5_ready2", LW'(hc_ready_out), LW'(1'b1));
        hc_we_in    = 1'b0;
        hc_value_in = '0;
        @(negedge clk_in);
        hc_valid_in = 1'b0;
        wait_resp("t5", 22'h0001C0, pat_c);
        quiet("t5_single", 20);

        // Test 6: reset during BUSY of a read with another read queued
        hc_valid_in = 1'b1;
        hc_we_in    = 1'b0;
        hc_addr_in  = 22'h000080;
        @(negedge clk_in);
        hc_addr_in  = 22'h000000;
        @(negedge clk_in);
        hc_valid_in = 1'b0;
        @(negedge clk_in);
        #2;
        rst_N_in = 1'b0;
        #1;
        check("t6_rst_valid", LW'(hc_valid_out), LW'(1'b0));
        @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
        check("t6_ready", LW'(hc_ready_out), LW'(1'b1));
        quiet("t6_noresp", 20);
        send(1'b0, 22'h000080, '0);
        wait_resp("t6_cleared", 22'h000080, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc_line_responder.md
Name: lc_line_responder

Overview:
- Lower-level line responder: the far end of the L1 data cache's lower-cache interface.
- Accepts line-granular read and writeback requests from an upper cache, queues them in order, and services each after a fixed latency from an internal line store.
- Returns one full line per read; writebacks complete silently, with no response.
- Used as the L2/DRAM stand-in beneath the L1D and as a reusable backing-store model.

Parameters:
- B, 64, line size in bytes (power of 2).
- PADDR_BITS, 22, physical address width.
- LINES, 256, number of lines in the store (power of 2).
- LATENCY, 4, service cycles per request (>=1).
- QDEPTH, 4, request FIFO depth (power of 2, >=2).

Ports:
- clk_in  in  1  clock.
- rst_N_in  in  1  reset; asynchronous assert, active-low.
- hc_valid_in  in  1  upper side presents a request.
- hc_ready_out  out  1  responder can accept a request.
- hc_addr_in  in  PADDR_BITS  request physical address.
- hc_value_in  in  8*B  writeback line data (ignored for reads).
- hc_we_in  in  1  1 = writeback, 0 = line read.
- hc_valid_out  out  1  read response valid.
- hc_ready_in  in  1  upper side accepts the response.
- hc_addr_out  out  PADDR_BITS  line-aligned address of the response.
- hc_value_out  out  8*B  line data of the response.

Behaviour:
- Reset values:
  - hc_valid_out=0, hc_addr_out=0, hc_value_out=0.
  - FIFO empty; FSM in IDLE; all per-line valid bits cleared.
  - hc_ready_out=1 as soon as reset deasserts.
- Line store: LINES entries of 8*B bits plus one valid bit per line. The data array itself is not reset.
- Index and alignment:
  - index = addr[$clog2(B) +: $clog2(LINES)].
  - Upper address bits are ignored, so addresses alias (wrap) modulo LINES*B.
- Accept:
  - A request is accepted at a rising edge where hc_valid_in && hc_ready_out.
  - {addr, we, value} is pushed into the FIFO.
  - hc_ready_out = (FIFO count < QDEPTH), derived from registered count only.
  - When the FIFO is full, a pop in the same cycle does not make room until the next cycle.
- FSM states: IDLE, BUSY, RESPOND.
  - IDLE: if the FIFO is non-empty, pop the head into a working register, load cnt=LATENCY-1, and go to BUSY.
  - BUSY: if cnt!=0, decrement cnt. When cnt==0:
    - Write: store the line, set its valid bit, go to IDLE.
    - Read: capture data (the store line if valid, else all zeros), drive hc_addr_out=addr with the low $clog2(B) bits zeroed, set hc_valid_out, go to RESPOND.
  - RESPOND: hold hc_valid_out, hc_addr_out and hc_value_out stable until hc_valid_out && hc_ready_in at an edge. Then clear hc_valid_out and go to IDLE.
  - The FIFO keeps accepting requests in every state.
- Latency:
  - Request accepted at edge E0 into an empty FIFO with the FSM in IDLE: pop at E1, completion at E1+LATENCY.
  - A read's hc_valid_out is high after edge E0+LATENCY+1.
  - Back-to-back service: a new pop occurs in the first IDLE cycle after completion.
- Ordering:
  - Requests are serviced strictly in arrival order, one at a time.
  - A read queued behind a write to the same line returns the written data.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - A response handshake and a new accept in the same cycle are independent.
- Reset mid-operation:
  - In-flight and queued requests are dropped; no response is issued.
  - Valid bits are cleared, so later reads return zero until the line is rewritten.
- FIFO pointers are $clog2(QDEPTH) bits and wrap naturally; count is $clog2(QDEPTH)+1 bits.

Decomposition:
- Package mem_line_pkg:
  - line_req_t packed struct {paddr, we, line}.
  - resp_state_t enum {IDLE, BUSY, RESPOND}.
  - Helper for line-address alignment.
- Sub-module line_req_fifo:
  - Parameterised by depth and element type; async active-low reset.
  - Ports: push, pop, din, dout, full, empty, count.
- The top level holds the FSM, latency counter, line store and valid bits.

Test Plan:
1. Reset, then read 0x000040 with no prior write -> hc_valid_out rises 5 cycles after accept; hc_addr_out=0x000040; hc_value_out=0.
2. Write 0x000080 with {8{64'hDEAD_BEEF_0000_0001}}, then read 0x0000A8 -> no response for the write; the read returns hc_addr_out=0x000080 with the same pattern.
3. Push 5 reads while holding hc_ready_in=0 -> hc_ready_out=0 after the 4th accept; the 5th request is stalled; the first response is held stable for 10 cycles until hc_ready_in=1.
4. Write 0x000000 with line A, then read 0x004000 (same index, LINES=256) -> the read returns A (alias/wrap).
5. Back-to-back write then read of 0x0001C0 accepted on consecutive cycles -> the read returns the new data and is the only response.
6. Assert rst_N_in low during BUSY of a read -> hc_valid_out=0 immediately; no response after release; FIFO empty; hc_ready_out=1.
